// File: rtl/hdmi_tx_pkg.sv
// Shared types and defaults for the HDMI transmitter init sequencer.
// The entry type is one {register, data} pair of the init table.
package hdmi_tx_pkg;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h39;
    localparam int         DEF_TBL_LEN  = 12;
    localparam int         RETRY_W      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOAD,
        ST_WAIT_ACK,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } tbl_entry_t;

endpackage

// File: rtl/hdmi_init_rom.sv
// Registered init-table ROM: the output updates one cycle after a read enable.
// It holds its value otherwise, so the I2C fields stay stable during a write.
import hdmi_tx_pkg::*;

module hdmi_init_rom (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] idx,
    output tbl_entry_t q
);

    tbl_entry_t rd;

    always_comb begin
        rd = '0;
        case (idx)
            4'd0:    rd = 16'h4110;
            4'd1:    rd = 16'h9803;
            4'd2:    rd = 16'h9AE0;
            4'd3:    rd = 16'h9C30;
            4'd4:    rd = 16'h9D61;
            4'd5:    rd = 16'hA2A4;
            4'd6:    rd = 16'hA3A4;
            4'd7:    rd = 16'hE0D0;
            4'd8:    rd = 16'hF900;
            4'd9:    rd = 16'h1500;
            4'd10:   rd = 16'h1630;
            4'd11:   rd = 16'hAF06;
            default: rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= rd;
    end

endmodule

// File: rtl/hdmi_tx_init_seq.sv
// Writes the HDMI transmitter init table over a byte-level I2C master after
// reset, on start and on every transmitter interrupt; retries NACKed writes.
import hdmi_tx_pkg::*;

module hdmi_tx_init_seq #(
    parameter logic [6:0] DEV_ADDR   = DEF_DEV_ADDR,
    parameter int         TBL_LEN    = DEF_TBL_LEN,
    parameter int         SETTLE_CYC = 50000,
    parameter int         RETRY_MAX  = 3
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       start,
    input  logic       hpd_int_n,
    output logic       i2c_req,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_reg,
    output logic [7:0] i2c_data,
    input  logic       i2c_ack,
    input  logic       i2c_nack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] idx
);

    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);
    localparam logic [3:0]         LAST_IDX  = 4'(TBL_LEN - 1);
    localparam logic [15:0]        SETTLE_LD = 16'(SETTLE_CYC - 1);

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic [2:0]           hpd_sh;
    logic                 hpd_fall, restart, rom_en;
    tbl_entry_t           rom_q;

    // hpd_sh[1:0] is the two-flop synchronizer, hpd_sh[2] the edge-detect history.
    // Reset to the idle-high level so reset release never looks like an interrupt.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) hpd_sh <= 3'b111;
        else       hpd_sh <= {hpd_sh[1:0], hpd_int_n};
    end

    assign hpd_fall = hpd_sh[2] & ~hpd_sh[1];
    assign restart  = start | hpd_fall;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        rom_en  = 1'b0;

        // Events during a run collapse into one rerun once the run ends.
        if (restart) pend_d = 1'b1;

        case (state_q)
            ST_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_LOAD: begin
                rom_en  = 1'b1;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (i2c_nack) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (i2c_ack) begin
                    retry_d = '0;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                // IDLE (automatic first run), DONE and ERR: any restart or a
                // rerun left pending by the previous run starts a fresh one.
                if (state_q == ST_IDLE || restart || pend_q) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LD;
                    idx_d   = '0;
                    retry_d = '0;
                    pend_d  = 1'b0;
                end else begin
                    pend_d  = pend_q;
                end
            end
        endcase
    end

    hdmi_init_rom u_rom (
        .clk (clk50),
        .rst (reset),
        .en  (rom_en),
        .idx (idx_q),
        .q   (rom_q)
    );

    // Request decodes straight off the async-reset state register, so a reset
    // mid-transfer drops it without waiting for a clock edge.
    assign i2c_req  = (state_q == ST_WAIT_ACK);
    assign i2c_addr = DEV_ADDR;
    assign i2c_reg  = rom_q.reg_addr;
    assign i2c_data = rom_q.data;
    assign busy     = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign done     = (state_q == ST_DONE);
    assign error    = (state_q == ST_ERR);
    assign idx      = idx_q;

endmodule

// File: tb/tb_hdmi_tx_init_seq.sv
// Self-checking bench: a time-scheduled behavioural model of the sequencer is
// compared with the DUT every cycle, plus literal checks per directed scenario.
module tb_hdmi_tx_init_seq;

    localparam int         S    = 4;
    localparam int         L    = 12;
    localparam int         RM   = 3;
    localparam logic [6:0] ADDR = 7'h39;

    logic       clk50 = 1'b0, reset = 1'b1, start = 1'b0, hpd_int_n = 1'b1;
    logic       i2c_ack = 1'b0, i2c_nack = 1'b0;
    logic       i2c_req, busy, done, error;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_reg, i2c_data;
    logic [3:0] idx;

    hdmi_tx_init_seq #(.DEV_ADDR(ADDR), .TBL_LEN(L), .SETTLE_CYC(S), .RETRY_MAX(RM)) dut (
        .clk50(clk50), .reset(reset), .start(start), .hpd_int_n(hpd_int_n),
        .i2c_req(i2c_req), .i2c_addr(i2c_addr), .i2c_reg(i2c_reg), .i2c_data(i2c_data),
        .i2c_ack(i2c_ack), .i2c_nack(i2c_nack),
        .busy(busy), .done(done), .error(error), .idx(idx)
    );

    always #10 clk50 = ~clk50;

    logic [15:0] tbl [L] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
                             16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'hAF06};

    int n_chk = 0, n_fail = 0, n_print = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // ---------------- behavioural model (event-time scheduling) ----------------
    bit         m_busy, m_done, m_err, m_req, boot, pend;
    logic [3:0] m_idx;
    logic [7:0] m_reg, m_data;
    int         tries, kcyc, req_edge, inc_edge, fin_edge;
    bit   [2:0] sh;

    task model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_req = 0; pend = 0; boot = 1;
        m_idx = '0; m_reg = '0; m_data = '0; tries = 0;
        req_edge = -1; inc_edge = -1; fin_edge = -1; sh = 3'b111;
    endtask

    // Run started by an event sampled at edge k: first request rises after edge k+S+1.
    task begin_run(input int k);
        m_busy = 1; m_done = 0; m_err = 0; m_idx = '0; tries = 0; pend = 0;
        req_edge = k + S + 1; inc_edge = -1; fin_edge = -1;
    endtask

    task model_edge();
        bit evt, restart, pre_busy, pre_req;
        kcyc++;
        evt = sh[2] & ~sh[1];
        sh = {sh[1:0], hpd_int_n};
        restart = start | evt;
        pre_busy = m_busy; pre_req = m_req;
        if (boot) begin
            boot = 0;
            begin_run(kcyc);
        end else if (!pre_busy) begin
            if (restart || pend) begin_run(kcyc);
        end else begin
            if (restart) pend = 1;
            if (pre_req && (i2c_ack || i2c_nack)) begin
                m_req = 0;
                if (i2c_nack) begin
                    if (tries < RM) begin tries++; req_edge = kcyc + 1; end
                    else begin m_busy = 0; m_err = 1; end
                end else begin
                    tries = 0;
                    if (int'(m_idx) == L - 1) fin_edge = kcyc + 1;
                    else begin inc_edge = kcyc + 1; req_edge = kcyc + 2; end
                end
            end
            if (kcyc == inc_edge) m_idx = m_idx + 4'd1;
            if (kcyc == fin_edge) begin m_busy = 0; m_done = 1; end
            if (kcyc == req_edge) begin
                m_req = 1;
                {m_reg, m_data} = tbl[m_idx];
            end
        end
    endtask

    always @(posedge clk50 or posedge reset) begin
        if (reset) model_reset();
        else       model_edge();
    end

    // Single compare process: every cycle, all outputs against the model.
    always @(negedge clk50) begin
        check("cycle{req,busy,done,err,idx,reg,data,addr}",
              {i2c_req, busy, done, error, idx, i2c_reg, i2c_data, i2c_addr},
              {m_req, m_busy, m_done, m_err, m_idx, m_reg, m_data, ADDR});
    end

    // ---------------- I2C engine responder ----------------
    bit         responded, prev_req, rand_mode;
    int         wait_cnt, max_delay, acks;
    int         nack_left [16];
    int         pres_cnt [256];
    logic [7:0] ack_regs [$];

    always @(negedge clk50) begin
        i2c_ack = 0; i2c_nack = 0;
        if (reset) begin
            responded = 0; prev_req = 0;
        end else begin
            if (i2c_req && !prev_req) pres_cnt[i2c_reg]++;
            prev_req = i2c_req;
            if (!i2c_req) begin
                responded = 0;
                wait_cnt = $urandom_range(max_delay, 0);
            end else if (!responded) begin
                if (wait_cnt > 0) wait_cnt--;
                else begin
                    responded = 1;
                    if (nack_left[idx] > 0) begin
                        nack_left[idx]--;
                        i2c_nack = 1;
                        if (rand_mode && $urandom_range(1, 0) == 1) i2c_ack = 1;
                    end else if (rand_mode && $urandom_range(9, 0) == 0) begin
                        i2c_nack = 1;
                        if ($urandom_range(1, 0) == 1) i2c_ack = 1;
                    end else begin
                        i2c_ack = 1;
                        acks++;
                        ack_regs.push_back(i2c_reg);
                    end
                end
            end
        end
    end

    task automatic clear_stats();
        acks = 0;
        ack_regs.delete();
        foreach (pres_cnt[i]) pres_cnt[i] = 0;
        foreach (nack_left[i]) nack_left[i] = 0;
    endtask

    // which: 0 done, 1 error, 2 !done, 3 !busy, 4 req at index tgt
    task automatic wait_until(input string name, input int which, input int tgt, input int maxc);
        int n; bit hit;
        n = 0; hit = 0;
        while (n < maxc && !hit) begin
            @(negedge clk50);
            n++;
            case (which)
                0:       hit = (done === 1'b1);
                1:       hit = (error === 1'b1);
                2:       hit = (done === 1'b0);
                3:       hit = (busy === 1'b0);
                default: hit = (i2c_req === 1'b1) && (int'(idx) == tgt);
            endcase
        end
        if (!hit) begin
            n_chk++; n_fail++;
            $display("FAIL timeout %s: waited %0d cycles, condition not reached", name, n);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk50) start = 1;
        @(negedge clk50) start = 0;
    endtask

    initial begin
        int e;
        max_delay = 0; rand_mode = 0;
        clear_stats();
        repeat (3) @(negedge clk50);
        check("rst_req", i2c_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_idx", idx, 0);
        check("rst_reg_data", {i2c_reg, i2c_data}, 0);
        check("rst_addr", i2c_addr, 7'h39);

        // 1: automatic run after reset, every write ACKed immediately
        reset = 0;
        e = 0;
        do begin @(negedge clk50); e++; end while (!i2c_req && e < 50);
        check("first_req_latency", e, S + 2);
        check("first_write", {i2c_reg, i2c_data}, 16'h4110);
        e = 0;
        do begin @(negedge clk50); e++; end while (!i2c_req && e < 50);
        check("ack_to_next_req", e, 3);
        check("second_write", {i2c_reg, i2c_data}, 16'h9803);
        wait_until("run1_done", 0, 0, 200);
        check("run1_writes", acks, 12);
        check("run1_first_reg", ack_regs[0], 8'h41);
        check("run1_last_reg", ack_regs[11], 8'hAF);
        check("run1_done_busy", {done, busy}, 2'b10);

        // 2: entry 3 NACKed twice, then ACKed
        clear_stats();
        nack_left[3] = 2;
        pulse_start();
        wait_until("run2_done", 0, 0, 300);
        check("run2_9c_presented", pres_cnt[8'h9C], 3);
        check("run2_error", error, 0);
        check("run2_writes", acks, 12);

        // 3: entry 5 NACKed four times -> ERR
        clear_stats();
        nack_left[5] = 4;
        pulse_start();
        wait_until("run3_err", 1, 0, 300);
        check("run3_err_idx", {error, idx, i2c_req}, {1'b1, 4'd5, 1'b0});
        check("run3_a2_presented", pres_cnt[8'hA2], 4);
        repeat (20) @(negedge clk50);
        check("run3_no_more_req", pres_cnt[8'hA2] + pres_cnt[8'hA3] + int'(i2c_req), 4);

        // 4: interrupt during entry 7 -> finish, then exactly one rerun
        clear_stats();
        pulse_start();
        wait_until("run4_idx7", 4, 7, 300);
        hpd_int_n = 0;
        repeat (3) @(negedge clk50);
        hpd_int_n = 1;
        wait_until("run4_done_a", 0, 0, 300);
        wait_until("run4_rerun", 2, 0, 5);
        wait_until("run4_done_b", 0, 0, 300);
        repeat (30) @(negedge clk50);
        check("run4_writes", acks, 24);
        check("run4_rerun_first", ack_regs[12], 8'h41);
        check("run4_final_done", {done, busy}, 2'b10);

        // 5: start and synchronized interrupt edge coinciding while in DONE
        clear_stats();
        @(negedge clk50) hpd_int_n = 0;
        @(negedge clk50);
        @(negedge clk50) start = 1;
        @(negedge clk50) start = 0;
        repeat (3) @(negedge clk50);
        hpd_int_n = 1;
        wait_until("run5_done", 0, 0, 300);
        repeat (40) @(negedge clk50);
        check("run5_writes", acks, 12);
        check("run5_41_presented", pres_cnt[8'h41], 1);

        // 6: randomized traffic, model checked every cycle
        clear_stats();
        rand_mode = 1; max_delay = 3;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk50);
            start = ($urandom_range(199, 0) == 0);
            if ($urandom_range(149, 0) == 0) hpd_int_n = ~hpd_int_n;
        end
        @(negedge clk50) start = 0;
        hpd_int_n = 1;
        wait_until("rand_quiesce", 3, 0, 3000);
        repeat (10) @(negedge clk50);

        // 7: reset in the middle of a write
        clear_stats();
        rand_mode = 0; max_delay = 2;
        pulse_start();
        wait_until("run7_idx2", 4, 2, 300);
        #3 reset = 1;
        #1 check("reset_drops_req", i2c_req, 0);
        repeat (3) @(negedge clk50);
        check("reset_idx_busy", {idx, busy}, 5'd0);
        reset = 0;
        clear_stats();
        wait_until("run7_done", 0, 0, 300);
        check("run7_writes", acks, 12);
        check("run7_first_reg", ack_regs[0], 8'h41);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_tx_init_seq.md
# hdmi_tx_init_seq

Hardware sequencer that configures the HDMI transmitter after reset, start or hot-plug by writing a fixed register table over a byte-level I2C master. It sits between the top level and the HDMI-side I2C engine, so the video output comes up without CPU involvement. The CPU keeps status visibility through `busy`, `done` and `error`. It retries NACKed writes and reruns the whole table on every transmitter interrupt.

## Interface
- `DEV_ADDR`, default 7'h39: 7-bit I2C address of the transmitter.
- `TBL_LEN`, default 12: number of table entries; range 1..16.
- `SETTLE_CYC`, default 50000: settle delay before the first write, in `clk50` cycles (1 ms).
- `RETRY_MAX`, default 3: retries per entry after a NACK.
- `clk50` in 1: clock, 50 MHz. One clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that requests a full rerun.
- `hpd_int_n` in 1: transmitter interrupt, active-low, asynchronous; synchronized internally with 2 FFs.
- `i2c_req` out 1: write request, level.
- `i2c_addr` out 7: device address; always `DEV_ADDR`.
- `i2c_reg` out 8: register address.
- `i2c_data` out 8: register data.
- `i2c_ack` in 1: one-cycle pulse, write completed with ACK.
- `i2c_nack` in 1: one-cycle pulse, write completed with NACK.
- `busy` out 1: high in every state except IDLE, DONE and ERR.
- `done` out 1: the table was fully written; clears when a sequence restarts.
- `error` out 1: retry limit was exceeded; sticky until the next restart.
- `idx` out 4: current table index.

## Operation
- States: IDLE, SETTLE, LOAD, WAIT_ACK, NEXT, DONE, ERR.
- Reset values:
  - all outputs 0, except `i2c_addr = DEV_ADDR`;
  - state IDLE; retry counter 0; pending flag 0.
- After reset release, the first clock goes IDLE→SETTLE (automatic initial run).
- SETTLE: load the counter with `SETTLE_CYC-1` and count down to 0, then go to LOAD with `idx=0`.
- LOAD: registered ROM read of entry `idx` into `i2c_reg` and `i2c_data`; go to WAIT_ACK.
- WAIT_ACK:
  - `i2c_req=1`; `i2c_reg` and `i2c_data` stay stable until a response arrives.
  - `i2c_ack` → NEXT with retry counter cleared.
  - `i2c_nack` → if retries < `RETRY_MAX`, increment retries and go to LOAD (same `idx`); otherwise go to ERR.
  - `i2c_ack` and `i2c_nack` in the same cycle are treated as NACK.
- NEXT: `i2c_req=0`. If `idx==TBL_LEN-1`, go to DONE; otherwise increment `idx` and go to LOAD.
- DONE: `done=1`. ERR: `error=1`; `idx` holds the failing entry.
- Restart event = `start` pulse, or a falling edge of synchronized `hpd_int_n`.
  - In IDLE, DONE or ERR: restart goes to SETTLE and clears `done`, `error`, retries and `idx`.
  - In SETTLE, LOAD, WAIT_ACK or NEXT: set the pending flag. When the run ends (DONE or ERR), a set pending flag forces SETTLE on the next cycle and clears the flag. `done`/`error` pulse for that one cycle.
  - Multiple events during one run collapse into a single rerun.
- Widths: `idx` is 4 bits and never exceeds `TBL_LEN-1`. The settle counter is 16 bits. Retries use 2 bits; `RETRY_MAX` ≤ 3.
- Reset mid-transaction: `i2c_req` drops asynchronously. The I2C engine treats a dropped request as an abort.

## Timing
- `start` sampled at edge N: SETTLE from N+1, LOAD at N+`SETTLE_CYC`+1, `i2c_req` high from N+`SETTLE_CYC`+2.
- `i2c_ack` sampled at edge A: `i2c_req` low from A+1 (NEXT), LOAD at A+2, next `i2c_req` high from A+3.
- NACK sampled at edge A: `i2c_req` low from A+1 (LOAD), high again from A+2 with identical `i2c_reg`/`i2c_data`.
- Last ACK at edge A: `done=1` and `busy=0` from A+2.
- `hpd_int_n` synchronizer latency: 2 cycles, plus 1 cycle for edge detection.

## Structure
- Package `hdmi_tx_pkg`: state enum, `DEV_ADDR`, `TBL_LEN`, the 16-bit `{reg,data}` entry type, and the retry width.
- Sub-module `hdmi_init_rom`: 1-cycle registered ROM, `idx`→`{reg,data}`. Contents in order:
  - 41/10, 98/03, 9A/E0, 9C/30, 9D/61, A2/A4;
  - A3/A4, E0/D0, F9/00, 15/00, 16/30, AF/06.
- The FSM, counters and synchronizer live in `hdmi_tx_init_seq`.

## Test plan
- Use `SETTLE_CYC=4` for all scenarios.
- Reset release, engine ACKs every request one cycle after `i2c_req` rises → 12 writes in ROM order, the first being reg 0x41 data 0x10; `done=1`; `busy=0`.
- Entry 3 NACKed twice, then ACKed → reg 0x9C is presented 3 times; the sequence completes; `error=0`.
- Entry 5 NACKed 4 times → ERR; `error=1`, `idx=5`, `i2c_req=0`; no further requests.
- `hpd_int_n` pulsed low during entry 7 → the current run finishes to DONE, then exactly one full rerun starting at reg 0x41; `done` is low during the rerun.
- `start` pulse and an `hpd_int_n` falling edge in the same cycle while in DONE → exactly one rerun.
- `reset` asserted mid-WAIT_ACK → `i2c_req` drops in the same cycle without waiting for a clock edge; after release the sequence restarts at `idx=0`.
